pwm_multi: RTL and testbench

PWM_MULTI -- requirements
Module: pwm_multi

---
 rtl/pwm_pkg.sv | 22 ++
 rtl/pwm_chan.sv | 46 ++++
 rtl/pwm_multi.sv | 159 +++++++++++++++
 tb/tb_pwm_multi.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared constants for the multi-channel PWM block: mode encodings, parameter ranges, counter direction.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pwm_pkg;

    // Counting modes as written through mode_in.
    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_CENTER = 1'b1;

    // Legal parameter ranges for channel count and counter width.
    localparam int CH_MIN = 1;
    localparam int CH_MAX = 16;
    localparam int CW_MIN = 4;
    localparam int CW_MAX = 16;

    // Direction of the shared period counter; DOWN only occurs in center mode.
    typedef enum logic {
        ST_UP   = 1'b0,
        ST_DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/pwm_chan.sv
// One PWM channel: active duty register, compare against the shared counter, registered output.
// Latency: pwm reflects the counter value of the previous cycle.
// Backpressure: none; the active duty only changes on load edges.
module pwm_chan #(
    parameter int   CW  = 8,
    parameter logic INV = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          load,
    input  logic [CW-1:0] duty_sh,
    input  logic [CW-1:0] cnt,
    input  logic          top_half,
    output logic          pwm
);

    logic [CW-1:0] duty_q;
    logic [CW-1:0] duty_d;
    logic          pwm_q;
    logic          pwm_d;
    logic          hit;

    // Active duty reloads from the shadow on load edges. In the descending half of a
    // center-aligned period (top cycle included) the compare is inclusive, so the high
    // window is exactly 2*D cycles, symmetric about cnt=0, and D>=P is solid high.
    always_comb begin
        duty_d = load ? duty_sh : duty_q;
        hit    = top_half ? (cnt <= duty_q) : (cnt < duty_q);
        pwm_d  = en ? (hit ^ INV) : INV;
    end

    // Channel state; the output idles at its inversion level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            duty_q <= '0;
            pwm_q  <= INV;
        end else begin
            duty_q <= duty_d;
            pwm_q  <= pwm_d;
        end
    end

    assign pwm = pwm_q;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: one shared edge/center-aligned counter, shadowed period/mode/duties per channel.
// Latency: pwm_out and cyc_start are registered one cycle after the counter value they reflect.
// Backpressure: none; writes land in shadows every cycle and go live at the next period boundary.
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int            CH       = 4,
    parameter int            CW       = 8,
    parameter logic [CH-1:0] INV_MASK = '0
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   en,
    input  logic                                   per_we,
    input  logic [CW-1:0]                          per_in,
    input  logic                                   mode_in,
    input  logic                                   duty_we,
    input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0] duty_addr,
    input  logic [CW-1:0]                          duty_in,
    output logic [CH-1:0]                          pwm_out,
    output logic                                   cyc_start
);

    // Shadow registers written by software.
    logic [CW-1:0] per_sh_q;
    logic [CW-1:0] per_sh_d;
    logic          mode_sh_q;
    logic          mode_sh_d;
    logic [CW-1:0] duty_sh_q [CH];
    logic [CW-1:0] duty_sh_d [CH];

    // Active period and mode used by the counter.
    logic [CW-1:0] per_act_q;
    logic [CW-1:0] per_act_d;
    logic          mode_act_q;
    logic          mode_act_d;

    // Shared counter and direction.
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    dir_e          dir_q;
    dir_e          dir_d;

    logic          cyc_start_q;
    logic          cyc_start_d;
    logic          wrap;
    logic          load;
    logic          top_half;

    // Shadow updates; writes to channel numbers beyond CH match no slot and are dropped.
    always_comb begin
        per_sh_d  = per_we ? per_in  : per_sh_q;
        mode_sh_d = per_we ? mode_in : mode_sh_q;
        for (int i = 0; i < CH; i++) begin
            duty_sh_d[i] = duty_sh_q[i];
            if (duty_we && (int'(duty_addr) == i)) begin
                duty_sh_d[i] = duty_in;
            end
        end
    end

    // Counter/direction next state: edge counts 0..P, center counts 0..P then P-1..1.
    // wrap marks the last cycle of a period, i.e. the edge where cnt returns to 0.
    always_comb begin
        cnt_d = cnt_q;
        dir_d = dir_q;
        wrap  = 1'b0;
        if (!en) begin
            cnt_d = '0;
            dir_d = ST_UP;
        end else if (mode_act_q == MODE_EDGE) begin
            dir_d = ST_UP;
            if (cnt_q >= per_act_q) begin
                cnt_d = '0;
                wrap  = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (dir_q == ST_UP) begin
            if (cnt_q >= per_act_q) begin
                // P of 0 or 1 has no descending half: go straight back to 0.
                if (per_act_q <= CW'(1)) begin
                    cnt_d = '0;
                    wrap  = 1'b1;
                end else begin
                    cnt_d = per_act_q - CW'(1);
                    dir_d = ST_DOWN;
                end
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            if (cnt_q <= CW'(1)) begin
                cnt_d = '0;
                dir_d = ST_UP;
                wrap  = 1'b1;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    // Shadows go live at every boundary and continuously while stopped, so a restart
    // always begins with the latest values. The flops sample the pre-write shadow.
    always_comb begin
        load        = !en || wrap;
        per_act_d   = load ? per_sh_q  : per_act_q;
        mode_act_d  = load ? mode_sh_q : mode_act_q;
        cyc_start_d = en && (cnt_q == '0);
        top_half    = (mode_act_q == MODE_CENTER) &&
                      ((dir_q == ST_DOWN) || ((cnt_q == per_act_q) && (per_act_q != '0)));
    end

    // Shared state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            per_sh_q    <= '0;
            mode_sh_q   <= MODE_EDGE;
            per_act_q   <= '0;
            mode_act_q  <= MODE_EDGE;
            cnt_q       <= '0;
            dir_q       <= ST_UP;
            cyc_start_q <= 1'b0;
            for (int i = 0; i < CH; i++) begin
                duty_sh_q[i] <= '0;
            end
        end else begin
            per_sh_q    <= per_sh_d;
            mode_sh_q   <= mode_sh_d;
            per_act_q   <= per_act_d;
            mode_act_q  <= mode_act_d;
            cnt_q       <= cnt_d;
            dir_q       <= dir_d;
            cyc_start_q <= cyc_start_d;
            for (int i = 0; i < CH; i++) begin
                duty_sh_q[i] <= duty_sh_d[i];
            end
        end
    end

    assign cyc_start = cyc_start_q;

    for (genvar g = 0; g < CH; g++) begin : g_chan
        pwm_chan #(
            .CW  (CW),
            .INV (INV_MASK[g])
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .load     (load),
            .duty_sh  (duty_sh_q[g]),
            .cnt      (cnt_q),
            .top_half (top_half),
            .pwm      (pwm_out[g])
        );
    end

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi with a period-position reference model feeding a scoreboard.
// Latency: expected outputs are pushed for each cycle and compared after the following edge.
// Backpressure: n/a.
module tb_pwm_multi;

    localparam int            CH  = 3;
    localparam int            CW  = 8;
    localparam logic [CH-1:0] INV = 3'b100;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          per_we;
    logic [CW-1:0] per_in;
    logic          mode_in;
    logic          duty_we;
    logic [1:0]    duty_addr;
    logic [CW-1:0] duty_in;
    logic [CH-1:0] pwm_out;
    logic          cyc_start;

    int errors = 0;
    int checks = 0;

    logic [CH-1:0] inv_v = INV;
    logic [CH:0]   exp_q[$];

    // Reference model: period position m_k plus shadow/active copies.
    int m_per_sh, m_mode_sh, m_per_a, m_mode_a, m_k;
    int m_d_sh[CH];
    int m_d_a[CH];

    // Per-window accumulators over sampled outputs.
    int          acc_hi[CH];
    logic [31:0] acc_vec[CH];
    int          acc_cy;
    int          acc_n;

    pwm_multi #(
        .CH       (CH),
        .CW       (CW),
        .INV_MASK (INV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .per_we    (per_we),
        .per_in    (per_in),
        .mode_in   (mode_in),
        .duty_we   (duty_we),
        .duty_addr (duty_addr),
        .duty_in   (duty_in),
        .pwm_out   (pwm_out),
        .cyc_start (cyc_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int m_len();
        if (m_mode_a != 0) return (m_per_a == 0) ? 1 : 2 * m_per_a;
        return m_per_a + 1;
    endfunction

    // High for the first D positions of the period; in center mode also for the last D.
    function automatic logic m_high(input int d, input int k);
        if (d == 0) return 1'b0;
        if (m_mode_a == 0) return (k < d);
        return (k < d) || (k >= 2 * m_per_a - d);
    endfunction

    task automatic m_load();
        m_per_a  = m_per_sh;
        m_mode_a = m_mode_sh;
        for (int i = 0; i < CH; i++) m_d_a[i] = m_d_sh[i];
    endtask

    task automatic model_step();
        logic [CH-1:0] eo;
        logic          ec;
        eo = inv_v;
        ec = 1'b0;
        if (!rst) begin
            m_per_sh = 0; m_mode_sh = 0; m_per_a = 0; m_mode_a = 0; m_k = 0;
            for (int i = 0; i < CH; i++) begin
                m_d_sh[i] = 0;
                m_d_a[i]  = 0;
            end
        end else begin
            if (en) begin
                for (int i = 0; i < CH; i++) eo[i] = m_high(m_d_a[i], m_k) ^ inv_v[i];
                ec = (m_k == 0);
                m_k++;
                if (m_k >= m_len()) begin
                    m_k = 0;
                    m_load();
                end
            end else begin
                m_k = 0;
                m_load();
            end
            if (per_we) begin
                m_per_sh  = int'(per_in);
                m_mode_sh = int'(mode_in);
            end
            if (duty_we && (int'(duty_addr) < CH)) m_d_sh[duty_addr] = int'(duty_in);
        end
        exp_q.push_back({ec, eo});
    endtask

    task automatic acc_clear();
        for (int i = 0; i < CH; i++) begin
            acc_hi[i]  = 0;
            acc_vec[i] = '0;
        end
        acc_cy = 0;
        acc_n  = 0;
    endtask

    // One clock: push expectation for this cycle, then pop and compare after the edge.
    task automatic cycle();
        logic [CH:0] e;
        model_step();
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard: observed empty queue expected one entry");
        end else begin
            e = exp_q.pop_front();
            chk("pwm_out", 32'(pwm_out), 32'(e[CH-1:0]));
            chk("cyc_start", 32'(cyc_start), 32'(e[CH]));
        end
        for (int i = 0; i < CH; i++) begin
            acc_hi[i] += int'(pwm_out[i]);
            if (acc_n < 32) acc_vec[i][acc_n] = pwm_out[i];
        end
        acc_cy += int'(cyc_start);
        acc_n++;
    endtask

    task automatic wr_per(input int p, input logic m);
        per_we  = 1'b1;
        per_in  = CW'(p);
        mode_in = m;
        cycle();
        per_we  = 1'b0;
    endtask

    task automatic wr_duty(input int a, input int d);
        duty_we   = 1'b1;
        duty_addr = 2'(a);
        duty_in   = CW'(d);
        cycle();
        duty_we   = 1'b0;
    endtask

    task automatic wait_cyc(input string tag, input int budget);
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            cycle();
            if (cyc_start === 1'b1) seen = 1'b1;
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    // Advance until the bench's own model is at the first cycle of a period.
    task automatic align(input int budget);
        for (int n = 0; n < budget && m_k != 0; n++) cycle();
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; per_we = 1'b0; per_in = '0; mode_in = 1'b0;
        duty_we = 1'b0; duty_addr = '0; duty_in = '0;
        acc_clear();
        #2 rst = 1'b0;
        #1;
        chk("reset_pwm", 32'(pwm_out), 32'(INV));
        chk("reset_cyc", 32'(cyc_start), 32'd0);
        repeat (2) cycle();
        rst = 1'b1;

        // Edge mode P=9, D0=3: 3 of 10 high, cyc_start every 10.
        wr_per(9, 1'b0);
        wr_duty(0, 3);
        wr_duty(1, 2);
        wr_duty(2, 5);
        en = 1'b1;
        wait_cyc("first_cyc", 30);
        align(30);
        acc_clear();
        repeat (20) cycle();
        chk("edge_hi0", acc_hi[0], 6);
        chk("edge_cyc", acc_cy, 2);
        chk("edge_pat_a", 32'(acc_vec[0][9:0]), 32'h007);
        chk("edge_pat_b", 32'(acc_vec[0][19:10]), 32'h007);

        // Mid-period duty write: current period keeps 2, next uses 7.
        acc_clear();
        repeat (5) cycle();
        wr_duty(1, 7);
        repeat (4) cycle();
        chk("mid_old_hi1", acc_hi[1], 2);
        acc_clear();
        repeat (10) cycle();
        chk("mid_new_hi1", acc_hi[1], 7);

        // Write to a channel number beyond CH changes nothing.
        acc_clear();
        wr_duty(3, 1);
        repeat (19) cycle();
        chk("badaddr_hi0", acc_hi[0], 6);
        chk("badaddr_hi1", acc_hi[1], 14);
        chk("badaddr_hi2", acc_hi[2], 10);

        // Period write in the boundary cycle: old P=9 runs once more, then P=4.
        repeat (9) cycle();
        wr_per(4, 1'b0);
        acc_clear();
        repeat (14) cycle();
        chk("per_bound_cyc", acc_cy, 2);
        cycle();

        // Center mode P=8: D1=4 gives 8 of 16 symmetric about cnt=0; D0=P is solid high.
        wr_per(8, 1'b1);
        wr_duty(1, 4);
        wr_duty(0, 8);
        align(20);
        acc_clear();
        repeat (32) cycle();
        chk("ctr_hi0", acc_hi[0], 32);
        chk("ctr_hi1", acc_hi[1], 16);
        chk("ctr_pat_a", acc_vec[1][15:0], 32'h0000_F00F);
        chk("ctr_pat_b", 32'(acc_vec[1][31:16]), 32'h0000_F00F);
        chk("ctr_cyc", acc_cy, 2);

        // Stopped: outputs idle at INV; restart uses the latest shadows.
        en = 1'b0;
        wr_per(255, 1'b1);
        wr_duty(0, 0);
        wr_duty(1, 255);
        wr_duty(2, 0);
        cycle();
        chk("stop_pwm", 32'(pwm_out), 32'(INV));
        chk("stop_cyc", 32'(cyc_start), 32'd0);
        en = 1'b1;
        acc_clear();
        repeat (600) cycle();
        chk("full_hi0", acc_hi[0], 0);
        chk("full_hi1", acc_hi[1], 600);
        chk("full_hi2", acc_hi[2], 600);
        chk("full_cyc", acc_cy, 2);
        wr_duty(2, 255);
        align(600);
        acc_clear();
        repeat (600) cycle();
        chk("full_inv_hi2", acc_hi[2], 0);
        chk("full_hi1b", acc_hi[1], 600);

        // Reset mid-period: immediate idle, then shadows are zero so outputs stay low.
        repeat (7) cycle();
        rst = 1'b0;
        #1;
        chk("midrst_pwm", 32'(pwm_out), 32'(INV));
        chk("midrst_cyc", 32'(cyc_start), 32'd0);
        exp_q.delete();
        repeat (3) cycle();
        rst = 1'b1;
        acc_clear();
        repeat (20) cycle();
        chk("post_rst_hi0", acc_hi[0], 0);
        chk("post_rst_hi1", acc_hi[1], 0);
        chk("post_rst_hi2", acc_hi[2], 20);
        chk("post_rst_cyc", acc_cy, 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
